// File: rtl/ram_ctrl.sv
// Memory controller arbitrating instruction-fetch and data ports onto one
// word-wide synchronous single-port RAM, with sub-word loads and read-modify-write stores.
module ram_ctrl #(
  parameter int ADDR_W = 14,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic              i_done,
  output logic [31:0]       i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_wen,
  input  logic [1:0]        d_size,
  input  logic              d_unsigned,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_done,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              ram_clk,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_store,
  output logic              ram_wen,
  input  logic [31:0]       ram_load
);

  typedef enum logic [2:0] {IDLE, RD, RMW_RD, RMW_WR, WR, DONE} state_e;

  localparam logic [1:0] LAT = RD_LAT[1:0];

  state_e              state_q;
  logic [1:0]          cnt_q;
  logic                dSel_q;
  logic [1:0]          size_q;
  logic                zext_q;
  logic [1:0]          lane_q;
  logic [15:0]         wdata_q;
  logic                iDone_q, iErr_q, dDone_q, dErr_q;
  logic [31:0]         iRdata_q, dRdata_q;
  logic [ADDR_W-1:0]   ramAddr_q;
  logic [31:0]         ramStore_q;
  logic                ramWen_q;

  logic [31:0] dHigh, iHigh;
  logic        dErr, iErr;

  // Anything above the RAM's byte range, or not naturally aligned, is rejected.
  always_comb begin
    dHigh = d_addr >> (ADDR_W + 2);
    iHigh = i_addr >> (ADDR_W + 2);
    dErr  = (|dHigh) || (d_size == 2'b11) ||
            (d_size == 2'b01 && d_addr[0]) ||
            (d_size == 2'b10 && (|d_addr[1:0]));
    iErr  = (|iHigh) || (|i_addr[1:0]);
  end

  function automatic logic [31:0] loadExtract(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] lane, input logic zext);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   r = zext ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   r = zext ? {16'b0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] storeMerge(input logic [31:0] word, input logic [15:0] wd,
                                             input logic [1:0] size, input logic [1:0] lane);
    logic [31:0] r;
    r = word;
    case (size)
      2'b00: r[{lane, 3'b000} +: 8] = wd[7:0];
      2'b01: begin
        if (lane[1]) r[31:16] = wd;
        else         r[15:0]  = wd;
      end
      default: ;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dSel_q     <= 1'b0;
      size_q     <= '0;
      zext_q     <= 1'b0;
      lane_q     <= '0;
      wdata_q    <= '0;
      iDone_q    <= 1'b0;
      iErr_q     <= 1'b0;
      iRdata_q   <= '0;
      dDone_q    <= 1'b0;
      dErr_q     <= 1'b0;
      dRdata_q   <= '0;
      ramAddr_q  <= '0;
      ramStore_q <= '0;
      ramWen_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          // Data port has fixed priority; a losing fetch simply stays pending.
          if (d_req) begin
            dSel_q  <= 1'b1;
            size_q  <= d_size;
            zext_q  <= d_unsigned;
            lane_q  <= d_addr[1:0];
            wdata_q <= d_wdata[15:0];
            if (dErr) begin
              dDone_q <= 1'b1;
              dErr_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              ramAddr_q <= d_addr[ADDR_W+1:2];
              if (d_wen && d_size == 2'b10) begin
                ramStore_q <= d_wdata;
                ramWen_q   <= 1'b1;
                state_q    <= WR;
              end else if (d_wen) begin
                state_q <= RMW_RD;
              end else begin
                state_q <= RD;
              end
            end
          end else if (i_req) begin
            dSel_q <= 1'b0;
            size_q <= 2'b10;
            zext_q <= 1'b0;
            lane_q <= 2'b00;
            if (iErr) begin
              iDone_q <= 1'b1;
              iErr_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              ramAddr_q <= i_addr[ADDR_W+1:2];
              state_q   <= RD;
            end
          end
        end
        RD: begin
          if (cnt_q == LAT) begin
            if (dSel_q) begin
              dRdata_q <= loadExtract(ram_load, size_q, lane_q, zext_q);
              dDone_q  <= 1'b1;
            end else begin
              iRdata_q <= ram_load;
              iDone_q  <= 1'b1;
            end
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
        RMW_RD: begin
          if (cnt_q == LAT) begin
            ramStore_q <= storeMerge(ram_load, wdata_q, size_q, lane_q);
            ramWen_q   <= 1'b1;
            state_q    <= RMW_WR;
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
        RMW_WR, WR: begin
          ramWen_q <= 1'b0;
          dDone_q  <= 1'b1;
          state_q  <= DONE;
        end
        DONE: begin
          iDone_q <= 1'b0;
          iErr_q  <= 1'b0;
          dDone_q <= 1'b0;
          dErr_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ram_clk   = clk;
  assign ram_addr  = ramAddr_q;
  assign ram_store = ramStore_q;
  assign ram_wen   = ramWen_q;
  assign i_done    = iDone_q;
  assign i_err     = iErr_q;
  assign i_rdata   = iRdata_q;
  assign d_done    = dDone_q;
  assign d_err     = dErr_q;
  assign d_rdata   = dRdata_q;

endmodule

// File: tb/tb_ram_ctrl.sv
// Bench for ram_ctrl: instance A uses a 1-cycle RAM model, instance B a 2-cycle one;
// expected results are queued when a request is issued and compared when it completes.
module tb_ram_ctrl;

  logic        clk;
  logic        rst;
  logic        iReqA, iReqB;
  logic [31:0] iAddr;
  logic        dReqA, dReqB;
  logic        dWen;
  logic [1:0]  dSize;
  logic        dUnsigned;
  logic [31:0] dAddr;
  logic [31:0] dWdata;

  logic        iDoneA, iErrA, dDoneA, dErrA, ramWenA, ramClkA;
  logic [31:0] iRdataA, dRdataA, ramStoreA, ramLoadA;
  logic [13:0] ramAddrA;
  logic        iDoneB, iErrB, dDoneB, dErrB, ramWenB, ramClkB;
  logic [31:0] iRdataB, dRdataB, ramStoreB, ramLoadB;
  logic [13:0] ramAddrB;

  logic [31:0] memA [0:16383];
  logic [31:0] memB [0:16383];
  logic [31:0] rqA1, rqB1, rqB2;

  int checks = 0;
  int passed = 0;
  int wenCntA = 0;
  int bothCnt = 0;

  typedef struct {
    bit          useB;
    bit          fetch;
    bit          wen;
    logic [1:0]  size;
    bit          uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expData;
    bit          chkData;
    logic        expErr;
    int          expLat;
  } op_t;

  op_t sbQ[$];

  ram_ctrl #(.ADDR_W(14), .RD_LAT(1)) dutA (
    .clk(clk), .rst(rst),
    .i_req(iReqA), .i_addr(iAddr), .i_done(iDoneA), .i_rdata(iRdataA), .i_err(iErrA),
    .d_req(dReqA), .d_wen(dWen), .d_size(dSize), .d_unsigned(dUnsigned), .d_addr(dAddr),
    .d_wdata(dWdata), .d_done(dDoneA), .d_rdata(dRdataA), .d_err(dErrA),
    .ram_clk(ramClkA), .ram_addr(ramAddrA), .ram_store(ramStoreA), .ram_wen(ramWenA),
    .ram_load(ramLoadA)
  );

  ram_ctrl #(.ADDR_W(14), .RD_LAT(2)) dutB (
    .clk(clk), .rst(rst),
    .i_req(iReqB), .i_addr(iAddr), .i_done(iDoneB), .i_rdata(iRdataB), .i_err(iErrB),
    .d_req(dReqB), .d_wen(dWen), .d_size(dSize), .d_unsigned(dUnsigned), .d_addr(dAddr),
    .d_wdata(dWdata), .d_done(dDoneB), .d_rdata(dRdataB), .d_err(dErrB),
    .ram_clk(ramClkB), .ram_addr(ramAddrB), .ram_store(ramStoreB), .ram_wen(ramWenB),
    .ram_load(ramLoadB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM models: latency 1 for A, latency 2 for B.
  always @(posedge clk) begin
    if (ramWenA) memA[ramAddrA] <= ramStoreA;
    rqA1 <= memA[ramAddrA];
    if (ramWenB) memB[ramAddrB] <= ramStoreB;
    rqB1 <= memB[ramAddrB];
    rqB2 <= rqB1;
  end
  assign ramLoadA = rqA1;
  assign ramLoadB = rqB2;

  always @(negedge clk) begin
    if (ramWenA) wenCntA++;
    if (iDoneA && dDoneA) bothCnt++;
  end

  function automatic op_t mkOp(input bit useB, input bit fetch, input bit wen, input logic [1:0] size,
                               input bit uns, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] expData, input bit chkData, input logic expErr,
                               input int expLat);
    op_t o;
    o.useB = useB; o.fetch = fetch; o.wen = wen; o.size = size; o.uns = uns;
    o.addr = addr; o.wdata = wdata; o.expData = expData; o.chkData = chkData;
    o.expErr = expErr; o.expLat = expLat;
    return o;
  endfunction

  // Drives one request and reports the completion; lat counts edges from E0 to done-high.
  task automatic applyStimulus(input op_t o, output logic [31:0] rdata, output logic err,
                               output int lat);
    logic done;
    @(negedge clk);
    iAddr = o.addr; dAddr = o.addr; dWen = o.wen; dSize = o.size;
    dUnsigned = o.uns; dWdata = o.wdata;
    if (o.fetch)     iReqA = 1'b1;
    else if (o.useB) dReqB = 1'b1;
    else             dReqA = 1'b1;
    lat = -1;
    done = 1'b0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      done = o.fetch ? iDoneA : (o.useB ? dDoneB : dDoneA);
    end
    if (!done) lat = 999;
    rdata = o.fetch ? iRdataA : (o.useB ? dRdataB : dRdataA);
    err   = o.fetch ? iErrA   : (o.useB ? dErrB   : dErrA);
    iReqA = 1'b0; dReqA = 1'b0; dReqB = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({iDoneA, iErrA, dDoneA, dErrA, ramWenA} !== 5'b0)
      $display("[TB] FAIL reset_flags: got %b, expected 00000", {iDoneA, iErrA, dDoneA, dErrA, ramWenA});
    else passed++;
    checks++;
    if ({iRdataA, dRdataA, ramStoreA} !== 96'b0 || ramAddrA !== 14'b0)
      $display("[TB] FAIL reset_data: got i=%h d=%h st=%h a=%h, expected 0", iRdataA, dRdataA, ramStoreA, ramAddrA);
    else passed++;
    checks++;
    if (ramClkA !== clk)
      $display("[TB] FAIL reset_ram_clk: got %b, expected %b", ramClkA, clk);
    else passed++;
    rst = 1'b0;
  endtask

  task automatic test_word_access();
    op_t ops[$];
    op_t e;
    logic [31:0] rd;
    logic er;
    int lat;
    int wen0;
    ops.push_back(mkOp(0, 0, 1, 2'b10, 0, 32'h100, 32'hDEADBEEF, 32'h0, 1, 0, 1));
    ops.push_back(mkOp(0, 0, 0, 2'b10, 0, 32'h100, 32'h0, 32'hDEADBEEF, 1, 0, 2));
    wen0 = wenCntA;
    for (int k = 0; k < ops.size(); k++) begin
      sbQ.push_back(ops[k]);
      applyStimulus(ops[k], rd, er, lat);
      e = sbQ.pop_front();
      checks++;
      if (lat !== e.expLat) $display("[TB] FAIL word_lat[%0d]: got %0d, expected %0d", k, lat, e.expLat);
      else passed++;
      checks++;
      if (er !== e.expErr) $display("[TB] FAIL word_err[%0d]: got %b, expected %b", k, er, e.expErr);
      else passed++;
      if (e.chkData) begin
        checks++;
        if (rd !== e.expData) $display("[TB] FAIL word_data[%0d]: got %h, expected %h", k, rd, e.expData);
        else passed++;
      end
    end
    checks++;
    if (wenCntA - wen0 !== 1) $display("[TB] FAIL word_wen_cycles: got %0d, expected 1", wenCntA - wen0);
    else passed++;
  endtask

  task automatic test_subword();
    op_t ops[$];
    op_t e;
    logic [31:0] rd;
    logic er;
    int lat;
    int wen0;
    ops.push_back(mkOp(0, 0, 1, 2'b10, 0, 32'h100, 32'h11223344, 32'hDEADBEEF, 1, 0, 1));
    ops.push_back(mkOp(0, 0, 1, 2'b00, 0, 32'h101, 32'h123456A5, 32'hDEADBEEF, 1, 0, 3));
    ops.push_back(mkOp(0, 0, 0, 2'b10, 0, 32'h100, 32'h0, 32'h1122A544, 1, 0, 2));
    ops.push_back(mkOp(0, 0, 0, 2'b00, 0, 32'h101, 32'h0, 32'hFFFFFFA5, 1, 0, 2));
    ops.push_back(mkOp(0, 0, 0, 2'b00, 1, 32'h101, 32'h0, 32'h000000A5, 1, 0, 2));
    ops.push_back(mkOp(0, 0, 0, 2'b00, 0, 32'h103, 32'h0, 32'h00000011, 1, 0, 2));
    ops.push_back(mkOp(0, 0, 1, 2'b01, 0, 32'h102, 32'hFFFF8001, 32'h00000011, 1, 0, 3));
    ops.push_back(mkOp(0, 0, 0, 2'b01, 0, 32'h102, 32'h0, 32'hFFFF8001, 1, 0, 2));
    ops.push_back(mkOp(0, 0, 0, 2'b01, 1, 32'h102, 32'h0, 32'h00008001, 1, 0, 2));
    ops.push_back(mkOp(0, 0, 0, 2'b01, 0, 32'h103, 32'h0, 32'h0, 0, 1, 0));
    ops.push_back(mkOp(0, 0, 0, 2'b10, 0, 32'h100, 32'h0, 32'h8001A544, 1, 0, 2));
    wen0 = wenCntA;
    for (int k = 0; k < ops.size(); k++) begin
      sbQ.push_back(ops[k]);
      applyStimulus(ops[k], rd, er, lat);
      e = sbQ.pop_front();
      checks++;
      if (lat !== e.expLat) $display("[TB] FAIL subword_lat[%0d]: got %0d, expected %0d", k, lat, e.expLat);
      else passed++;
      checks++;
      if (er !== e.expErr) $display("[TB] FAIL subword_err[%0d]: got %b, expected %b", k, er, e.expErr);
      else passed++;
      if (e.chkData) begin
        checks++;
        if (rd !== e.expData) $display("[TB] FAIL subword_data[%0d]: got %h, expected %h", k, rd, e.expData);
        else passed++;
      end
    end
    checks++;
    if (wenCntA - wen0 !== 3) $display("[TB] FAIL subword_wen_cycles: got %0d, expected 3", wenCntA - wen0);
    else passed++;
  endtask

  task automatic test_errors();
    op_t ops[$];
    op_t e;
    logic [31:0] rd;
    logic er;
    int lat;
    int wen0;
    ops.push_back(mkOp(0, 0, 0, 2'b10, 0, 32'h0001_0000, 32'h0, 32'h0, 0, 1, 0));
    ops.push_back(mkOp(0, 0, 0, 2'b11, 0, 32'h100, 32'h0, 32'h0, 0, 1, 0));
    ops.push_back(mkOp(0, 0, 1, 2'b10, 0, 32'h102, 32'h55555555, 32'h0, 0, 1, 0));
    ops.push_back(mkOp(0, 0, 1, 2'b10, 0, 32'h0000_FFFC, 32'h0BADCAFE, 32'h0, 0, 0, 1));
    ops.push_back(mkOp(0, 0, 0, 2'b10, 0, 32'h0000_FFFC, 32'h0, 32'h0BADCAFE, 1, 0, 2));
    ops.push_back(mkOp(0, 1, 0, 2'b10, 0, 32'h102, 32'h0, 32'h0, 0, 1, 0));
    ops.push_back(mkOp(0, 1, 0, 2'b10, 0, 32'h100, 32'h0, 32'h8001A544, 1, 0, 2));
    ops.push_back(mkOp(0, 1, 0, 2'b10, 0, 32'h0004_0100, 32'h0, 32'h0, 0, 1, 0));
    wen0 = wenCntA;
    for (int k = 0; k < ops.size(); k++) begin
      sbQ.push_back(ops[k]);
      applyStimulus(ops[k], rd, er, lat);
      e = sbQ.pop_front();
      checks++;
      if (lat !== e.expLat) $display("[TB] FAIL errors_lat[%0d]: got %0d, expected %0d", k, lat, e.expLat);
      else passed++;
      checks++;
      if (er !== e.expErr) $display("[TB] FAIL errors_err[%0d]: got %b, expected %b", k, er, e.expErr);
      else passed++;
      if (e.chkData) begin
        checks++;
        if (rd !== e.expData) $display("[TB] FAIL errors_data[%0d]: got %h, expected %h", k, rd, e.expData);
        else passed++;
      end
    end
    checks++;
    if (wenCntA - wen0 !== 1) $display("[TB] FAIL errors_wen_cycles: got %0d, expected 1", wenCntA - wen0);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int n;
    int m;
    int both0;
    both0 = bothCnt;
    @(negedge clk);
    dAddr = 32'h100; dWen = 1'b0; dSize = 2'b10; dUnsigned = 1'b0;
    iAddr = 32'h100;
    dReqA = 1'b1; iReqA = 1'b1;
    n = 0;
    while (!dDoneA && !iDoneA && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (dDoneA !== 1'b1 || iDoneA !== 1'b0 || n !== 3)
      $display("[TB] FAIL arb_data_first: got d_done=%b i_done=%b after %0d, expected 1 0 after 3", dDoneA, iDoneA, n);
    else passed++;
    checks++;
    if (dRdataA !== 32'h8001A544) $display("[TB] FAIL arb_d_rdata: got %h, expected 8001a544", dRdataA);
    else passed++;
    dReqA = 1'b0;
    m = 0;
    while (!iDoneA && m < 20) begin
      @(negedge clk);
      m++;
    end
    checks++;
    if (m !== 4) $display("[TB] FAIL arb_fetch_delay: got %0d, expected 4", m);
    else passed++;
    checks++;
    if (iRdataA !== 32'h8001A544 || iErrA !== 1'b0)
      $display("[TB] FAIL arb_i_rdata: got %h err %b, expected 8001a544 err 0", iRdataA, iErrA);
    else passed++;
    iReqA = 1'b0;
    checks++;
    if (bothCnt !== both0) $display("[TB] FAIL arb_both_done: got %0d cycles, expected 0", bothCnt - both0);
    else passed++;
  endtask

  task automatic test_reset_mid_rmw();
    logic [31:0] rd;
    logic er;
    int lat;
    int n;
    applyStimulus(mkOp(0, 0, 1, 2'b10, 0, 32'h200, 32'hCAFEF00D, 32'h0, 0, 0, 1), rd, er, lat);
    @(negedge clk);
    dAddr = 32'h201; dWen = 1'b1; dSize = 2'b00; dUnsigned = 1'b0; dWdata = 32'h77;
    dReqA = 1'b1;
    n = 0;
    while (!ramWenA && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (ramWenA !== 1'b1 || n !== 3)
      $display("[TB] FAIL rst_rmw_reach: got ram_wen=%b after %0d, expected 1 after 3", ramWenA, n);
    else passed++;
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({ramWenA, dDoneA, dErrA, iDoneA} !== 4'b0 || ramAddrA !== 14'b0 || ramStoreA !== 32'b0 || dRdataA !== 32'b0)
      $display("[TB] FAIL rst_async: got wen=%b done=%b addr=%h store=%h rdata=%h, expected all 0",
               ramWenA, dDoneA, ramAddrA, ramStoreA, dRdataA);
    else passed++;
    dReqA = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(mkOp(0, 0, 0, 2'b10, 0, 32'h200, 32'h0, 32'h0, 0, 0, 2), rd, er, lat);
    checks++;
    if (rd !== 32'hCAFEF00D || er !== 1'b0 || lat !== 2)
      $display("[TB] FAIL rst_recover_read: got %h err %b lat %0d, expected cafef00d err 0 lat 2", rd, er, lat);
    else passed++;
  endtask

  task automatic test_read_latency2();
    op_t ops[$];
    op_t e;
    logic [31:0] rd;
    logic er;
    int lat;
    ops.push_back(mkOp(1, 0, 1, 2'b10, 0, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0, 1));
    ops.push_back(mkOp(1, 0, 0, 2'b10, 0, 32'h100, 32'h0, 32'hDEADBEEF, 1, 0, 3));
    ops.push_back(mkOp(1, 0, 1, 2'b00, 0, 32'h101, 32'h0000005A, 32'hDEADBEEF, 1, 0, 4));
    ops.push_back(mkOp(1, 0, 0, 2'b00, 1, 32'h101, 32'h0, 32'h0000005A, 1, 0, 3));
    ops.push_back(mkOp(1, 0, 0, 2'b01, 0, 32'h102, 32'h0, 32'hFFFFDEAD, 1, 0, 3));
    for (int k = 0; k < ops.size(); k++) begin
      sbQ.push_back(ops[k]);
      applyStimulus(ops[k], rd, er, lat);
      e = sbQ.pop_front();
      checks++;
      if (lat !== e.expLat) $display("[TB] FAIL lat2_lat[%0d]: got %0d, expected %0d", k, lat, e.expLat);
      else passed++;
      checks++;
      if (er !== e.expErr) $display("[TB] FAIL lat2_err[%0d]: got %b, expected %b", k, er, e.expErr);
      else passed++;
      if (e.chkData) begin
        checks++;
        if (rd !== e.expData) $display("[TB] FAIL lat2_data[%0d]: got %h, expected %h", k, rd, e.expData);
        else passed++;
      end
    end
  endtask

  task automatic checkOutput();
    checks++;
    if (sbQ.size() !== 0) $display("[TB] FAIL scoreboard_empty: got %0d left, expected 0", sbQ.size());
    else passed++;
  endtask

  initial begin
    rst = 1'b1;
    iReqA = 1'b0; iReqB = 1'b0; dReqA = 1'b0; dReqB = 1'b0;
    iAddr = '0; dAddr = '0; dWen = 1'b0; dSize = 2'b00; dUnsigned = 1'b0; dWdata = '0;
    test_reset();
    test_word_access();
    test_subword();
    test_errors();
    test_back_to_back();
    test_reset_mid_rmw();
    test_read_latency2();
    checkOutput();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
